systolic_feeder: RTL

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

---
 rtl/systolic_feeder_pkg.sv | 19 +
 rtl/feeder_skid_buf.sv | 66 ++++++
 rtl/systolic_feeder.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/systolic_feeder_pkg.sv
// Shared definitions for the systolic array feeder.
// Holds the feeder FSM state encoding and the default geometry constants
// (array size, operand width, buffer address width) used as parameter defaults.
package systolic_feeder_pkg;

   localparam int unsigned DEF_ARRAY_SIZE = 4;
   localparam int unsigned DEF_DATA_WIDTH = 8;
   localparam int unsigned DEF_ADDR_WIDTH = 10;

   typedef enum logic [2:0] {
      StIdle,
      StWload,
      StStart,
      StStream,
      StWaitDone,
      StFinish
   } feeder_state_e;

endpackage

// File: rtl/feeder_skid_buf.sv
// Two-entry valid/ready buffer between the activation buffer read port and the array.
// Ports:
//   clk, rst            clock, synchronous active-high reset (empties the buffer)
//   in_valid, in_data   write side; a write while full is dropped (the feeder never does this)
//   out_valid, out_data read side, driven directly from the head register
//   out_ready           consumer accepts the head entry when high
//   count               current occupancy (0..2), used by the feeder to throttle reads
module feeder_skid_buf
   import systolic_feeder_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_ARRAY_SIZE * DEF_DATA_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] head_q;
   logic [WIDTH-1:0] tail_q;
   logic [1:0]       count_q;
   logic             push;
   logic             pop;

   assign pop  = (count_q != 2'd0) && out_ready;
   assign push = in_valid && (count_q != 2'd2);

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count_q == 2'd0) head_q <= in_data;
               else                 tail_q <= in_data;
               count_q <= count_q + 2'd1;
            end
            2'b01: begin
               head_q  <= tail_q;
               count_q <= count_q - 2'd1;
            end
            2'b11: begin
               // Simultaneous pop and push keeps occupancy; new data goes behind any survivor.
               if (count_q == 2'd1) begin
                  head_q <= in_data;
               end else begin
                  head_q <= tail_q;
                  tail_q <= in_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign out_valid = (count_q != 2'd0);
   assign out_data  = head_q;
   assign count     = count_q;

endmodule

// File: rtl/systolic_feeder.sv
// Systolic array feeder: per command, loads ARRAY_SIZE weight columns from the weight
// buffer, pulses start (with clear_acc), streams M activation rows from the activation
// buffer through a 2-entry skid buffer, waits for array_done, then pulses done.
// Ports:
//   clk, rst                         clock, synchronous active-high reset (aborts command)
//   cmd_*                            command handshake and fields (latched on transfer)
//   wbuf_rd_* / abuf_rd_*            buffer read ports, data returns one cycle after rd_en
//   weight_load_en/col/data          weight column load into the array
//   start, clear_acc                 one-cycle compute start
//   act_valid/act_data/act_ready     activation row stream into the array
//   array_done, busy, done           completion handshake and status
//   stall_cycles                     backpressure cycle counter
// Optional feature: define FEEDER_PERF_CNT_EN to build the stall_cycles counter;
// otherwise stall_cycles is tied to zero.
module systolic_feeder
   import systolic_feeder_pkg::*;
#(
   parameter int unsigned ARRAY_SIZE = DEF_ARRAY_SIZE,
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             cmd_valid,
   output logic                             cmd_ready,
   input  logic [ADDR_WIDTH-1:0]            cmd_w_base,
   input  logic [ADDR_WIDTH-1:0]            cmd_a_base,
   input  logic [15:0]                      cmd_m_rows,
   input  logic                             cmd_clear,
   output logic                             wbuf_rd_en,
   output logic [ADDR_WIDTH-1:0]            wbuf_rd_addr,
   input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] wbuf_rd_data,
   output logic                             abuf_rd_en,
   output logic [ADDR_WIDTH-1:0]            abuf_rd_addr,
   input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] abuf_rd_data,
   output logic                             weight_load_en,
   output logic [$clog2(ARRAY_SIZE)-1:0]    weight_load_col,
   output logic [ARRAY_SIZE*DATA_WIDTH-1:0] weight_load_data,
   output logic                             start,
   output logic                             clear_acc,
   output logic                             act_valid,
   output logic [ARRAY_SIZE*DATA_WIDTH-1:0] act_data,
   input  logic                             act_ready,
   input  logic                             array_done,
   output logic                             busy,
   output logic                             done,
   output logic [31:0]                      stall_cycles
);

   localparam int unsigned RowW = ARRAY_SIZE * DATA_WIDTH;
   localparam int unsigned CntW = $clog2(ARRAY_SIZE + 1);
   localparam int unsigned ColW = $clog2(ARRAY_SIZE);

   feeder_state_e         state_q;
   logic [ADDR_WIDTH-1:0] w_base_q;
   logic [ADDR_WIDTH-1:0] a_base_q;
   logic [15:0]           m_rows_q;
   logic                  clear_q;
   logic [CntW-1:0]       wcnt_q;     // WLOAD cycle index, 0..ARRAY_SIZE
   logic [15:0]           rd_cnt_q;   // activation rows read
   logic [15:0]           acc_cnt_q;  // activation rows accepted by the array
   logic                  inflight_q; // abuf read data arrives this cycle

   logic                  cmd_fire;
   logic                  pop;
   logic [1:0]            skid_count;
   logic [2:0]            occ;

   assign cmd_fire = (state_q == StIdle) && cmd_valid;
   assign pop      = act_valid && act_ready;

   // Occupancy once this cycle's pop and the returning read settle; counting the pop lets
   // a read issue every cycle while the array keeps accepting.
   assign occ = 3'(skid_count) + 3'(inflight_q) - 3'(pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         w_base_q   <= '0;
         a_base_q   <= '0;
         m_rows_q   <= '0;
         clear_q    <= 1'b0;
         wcnt_q     <= '0;
         rd_cnt_q   <= '0;
         acc_cnt_q  <= '0;
         inflight_q <= 1'b0;
      end else begin
         inflight_q <= abuf_rd_en;
         if (abuf_rd_en) rd_cnt_q <= rd_cnt_q + 16'd1;
         if (pop) acc_cnt_q <= acc_cnt_q + 16'd1;
         case (state_q)
            StIdle: begin
               if (cmd_valid) begin
                  w_base_q  <= cmd_w_base;
                  a_base_q  <= cmd_a_base;
                  m_rows_q  <= cmd_m_rows;
                  clear_q   <= cmd_clear;
                  wcnt_q    <= '0;
                  rd_cnt_q  <= '0;
                  acc_cnt_q <= '0;
                  state_q   <= (cmd_m_rows == 16'd0) ? StFinish : StWload;
               end
            end
            StWload: begin
               if (wcnt_q == CntW'(ARRAY_SIZE)) state_q <= StStart;
               else                             wcnt_q  <= wcnt_q + 1'b1;
            end
            StStart:    state_q <= StStream;
            StStream: begin
               if (pop && (acc_cnt_q == m_rows_q - 16'd1)) state_q <= StWaitDone;
            end
            StWaitDone: begin
               if (array_done) state_q <= StFinish;
            end
            StFinish:   state_q <= StIdle;
            default:    state_q <= StIdle;
         endcase
      end
   end

   // Outputs decode directly from state flops; weight data is the buffer's one-cycle-late
   // read data, valid in exactly the cycle its column is loaded.
   assign cmd_ready        = (state_q == StIdle);
   assign busy             = (state_q != StIdle);
   assign done             = (state_q == StFinish);
   assign start            = (state_q == StStart);
   assign clear_acc        = start && clear_q;

   assign wbuf_rd_en       = (state_q == StWload) && (wcnt_q < CntW'(ARRAY_SIZE));
   assign wbuf_rd_addr     = wbuf_rd_en ? (w_base_q + ADDR_WIDTH'(wcnt_q)) : '0;
   assign weight_load_en   = (state_q == StWload) && (wcnt_q != '0);
   assign weight_load_col  = weight_load_en ? ColW'(wcnt_q - 1'b1) : '0;
   assign weight_load_data = weight_load_en ? wbuf_rd_data : '0;

   assign abuf_rd_en       = (state_q == StStream) && (rd_cnt_q < m_rows_q) && (occ < 3'd2);
   assign abuf_rd_addr     = abuf_rd_en ? (a_base_q + ADDR_WIDTH'(rd_cnt_q)) : '0;

   feeder_skid_buf #(
      .WIDTH(RowW)
   ) u_skid (
      .clk      (clk),
      .rst      (rst),
      .in_valid (inflight_q),
      .in_data  (abuf_rd_data),
      .out_valid(act_valid),
      .out_data (act_data),
      .out_ready(act_ready),
      .count    (skid_count)
   );

`ifdef FEEDER_PERF_CNT_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
      end else if (cmd_fire) begin
         stall_q <= '0;
      end else if (act_valid && !act_ready && (stall_q != '1)) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign stall_cycles = stall_q;
`else
   logic unused_cmd_fire;
   assign unused_cmd_fire = cmd_fire;
   assign stall_cycles    = '0;
`endif

endmodule
